alu_sequencer: RTL
==================

# alu_sequencer

Sequential request/response front-end that drives the 32-bit combinational ALU and consumes its result and flags. Accepts one operation per valid/ready handshake, presents registered operands and command to the ALU, captures result plus carryout/zero/overflow, and returns them on a backpressurable response channel. It also keeps a 32-bit accumulator for chained operations and a sticky overflow flag. It sits between the datapath controller and the ALU instance.

## Interface
- No parameters; width fixed at 32, command width fixed at 3.
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_command  in  3  ALU command: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR
- req_a  in  32  operand A
- req_b  in  32  operand B
- req_use_acc  in  1  1: use accumulator in place of req_a
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_result  out  32  captured ALU result
- resp_carryout, resp_zero, resp_overflow  out  1 each  captured ALU flags
- acc  out  32  accumulator value
- sticky_overflow  out  1  set by any captured overflow
- sticky_clear  in  1  clears sticky_overflow
- alu_operandA, alu_operandB  out  32 each  registered operands to the ALU
- alu_command  out  3  registered command to the ALU
- alu_result  in  32; alu_carryout, alu_zero, alu_overflow  in  1 each  combinational ALU outputs

## Operation
- States: IDLE, ISSUE, RESP. Reset state IDLE.
- IDLE: req_ready=1. On req_valid&&req_ready: latch alu_operandA = req_use_acc ? acc : req_a, alu_operandB = req_b, alu_command = req_command; go ISSUE. req_* ignored when req_valid=0.
- ISSUE: req_ready=0. ALU settles on registered inputs within the cycle; at the edge capture alu_result/flags into resp_* registers, write alu_result into acc, go RESP.
- RESP: resp_valid=1, resp_* stable. On resp_ready go IDLE; otherwise hold indefinitely with no change to resp_*, acc, alu_*.
- Flags passed through unmodified; ALU forces carryout/zero/overflow to 0 for commands 2–7, and the sequencer does not recompute them.
- acc updated for every command, including SLT (0 or 1) and logic ops.
- sticky_overflow: set at the ISSUE capture edge when alu_overflow=1; cleared when sticky_clear=1 at any edge. Simultaneous set and clear: set wins.
- alu_* registers hold their last value outside ISSUE (no toggling while idle).

## Timing
- Reset (reset_n=0 at an edge): state IDLE, req_ready=1 after the edge, resp_valid=0, resp_result=0, all resp flags 0, acc=0, sticky_overflow=0, alu_operandA/B=0, alu_command=0. Applies mid-operation: in-flight request and pending response are dropped, acc not updated.
- Acceptance edge = cycle 0; ISSUE during cycle 1; resp_valid high from cycle 2. Minimum latency 2 cycles, zero-backpressure throughput 1 op per 3 cycles.
- resp_ready sampled only in RESP; resp_ready=1 in other states has no effect.
- req_ready is a pure function of state (IDLE); no combinational path from req_valid or resp_ready to req_ready.
- req_use_acc with a back-to-back request reads acc as written by the previous operation's ISSUE edge.

## Test plan
- Reset: hold reset_n=0 two cycles with req_valid=1 → req_ready=1, resp_valid=0, acc=0, all alu_* =0; no request accepted.
- ADD 0x7FFFFFFF + 0x00000001 → resp_valid at cycle 2, resp_result=0x80000000, overflow=1, carryout=0, zero=0, sticky_overflow=1, acc=0x80000000.
- SUB 5 − 5 → result 0, zero=1, carryout=1, overflow=0; then sticky_clear=1 concurrent with ADD 0x7FFFFFFF+1 capture → sticky_overflow remains 1.
- SLT A=0xFFFFFFFF, B=0x00000001 → result 1; then req_use_acc=1, ADD B=0x00000002 → alu_operandA=1, result 3, acc=3.
- Backpressure: resp_ready=0 for 5 cycles in RESP with req_valid=1 and changing req_* → req_ready=0, resp_* and acc unchanged; resp_ready=1 → IDLE next cycle, next request accepted.
- Reset mid-operation: assert reset_n=0 during ISSUE of XOR 0xFFFF0000^0x0F0F0F0F → acc stays 0, resp_valid never rises, state IDLE after release.

Source files
------------

// File: rtl/alu_sequencer.sv
// Request/response front-end for the 32-bit combinational ALU: registers operands,
// captures result and flags, keeps a chaining accumulator and a sticky overflow flag.
module alu_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_command,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        req_use_acc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic        resp_carryout,
    output logic        resp_zero,
    output logic        resp_overflow,
    output logic [31:0] acc,
    output logic        sticky_overflow,
    input  logic        sticky_clear,
    output logic [31:0] alu_operandA,
    output logic [31:0] alu_operandB,
    output logic [2:0]  alu_command,
    input  logic [31:0] alu_result,
    input  logic        alu_carryout,
    input  logic        alu_zero,
    input  logic        alu_overflow
);

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CMD_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   accept;
    logic   capture;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                capture    = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake outputs registered from the next state so they track state exactly
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
        end else begin
            req_ready  <= (state_next == IDLE);
            resp_valid <= (state_next == RESP);
        end
    end

    // Operand registers only move on acceptance so the ALU inputs stay quiet while idle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            alu_operandA <= WIDTH'(0);
            alu_operandB <= WIDTH'(0);
            alu_command  <= CMD_W'(0);
        end else if (accept) begin
            alu_operandA <= req_use_acc ? acc : req_a;
            alu_operandB <= req_b;
            alu_command  <= req_command;
        end
    end

    // Result capture and accumulator write-back
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            resp_result   <= WIDTH'(0);
            resp_carryout <= 1'b0;
            resp_zero     <= 1'b0;
            resp_overflow <= 1'b0;
            acc           <= WIDTH'(0);
        end else if (capture) begin
            resp_result   <= alu_result;
            resp_carryout <= alu_carryout;
            resp_zero     <= alu_zero;
            resp_overflow <= alu_overflow;
            acc           <= alu_result;
        end
    end

    // Sticky overflow: a captured overflow beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sticky_overflow <= 1'b0;
        end else if (capture && alu_overflow) begin
            sticky_overflow <= 1'b1;
        end else if (sticky_clear) begin
            sticky_overflow <= 1'b0;
        end
    end

endmodule
